// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: FSM states, access size codes
// and the encoding of which requester currently owns (or last owned) the bus.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } arb_state_e;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } grant_side_e;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the fetch, load/store and external memory bus signals.
// slave  : the arbiter itself
// master : whatever surrounds it (core requesters plus the memory)
interface mem_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;

    logic          d_req;
    logic          d_write;
    logic [1:0]    d_size;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;

    logic          m_req;
    logic          m_write;
    logic [1:0]    m_size;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ack_n;

    logic          err;

    modport slave (
        input  i_req, i_addr, d_req, d_write, d_size, d_addr, d_wdata,
        input  m_rdata, m_ack_n,
        output i_rdata, i_ack, d_rdata, d_ack,
        output m_req, m_write, m_size, m_addr, m_wdata, err
    );

    modport master (
        output i_req, i_addr, d_req, d_write, d_size, d_addr, d_wdata,
        output m_rdata, m_ack_n,
        input  i_rdata, i_ack, d_rdata, d_ack,
        input  m_req, m_write, m_size, m_addr, m_wdata, err
    );

endinterface

// File: rtl/mem_bus_arbiter_ctr.sv
// Grant watchdog: counts cycles spent in a grant state and flags the cycle
// that would be the TIMEOUT-th one, so the arbiter can abort on that edge.
module arb_timeout_ctr #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign cnt_d     = cnt_q + CW'(1);
    assign expired_o = en_i && (cnt_d == CW'(TIMEOUT));

    // Cycle counter, cleared while the arbiter is idle.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter sharing one memory bus between instruction
// fetch and load/store. Optional grant timeout enabled by ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | bus free, choosing next requester (acked side ignored for 1 cycle)
// GNT_I | fetch owns the bus, waiting for m_ack_n low
// GNT_D | load/store owns the bus, waiting for m_ack_n low
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input logic              clk,
    input logic              rst,
    mem_bus_arbiter_if.slave bus
);
    if (TIMEOUT < 1) begin : g_timeout_check
        $error("TIMEOUT must be at least 1");
    end

    arb_state_e    state_q, state_d;
    grant_side_e   last_q, last_d;
    logic          m_req_q, m_req_d;
    logic          m_write_q, m_write_d;
    logic [1:0]    m_size_q, m_size_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          err_q, err_d;

    logic          timeout_hit;
    logic          want_i;
    logic          want_d;
    logic          done;
    logic [DW-1:0] rdata_cap;

`ifdef ARB_TIMEOUT_EN
    arb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q == IDLE),
        .en_i      (state_q != IDLE),
        .expired_o (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // A side still seeing its ack pulse has not had a chance to drop req yet.
    assign want_i    = bus.i_req && !i_ack_q;
    assign want_d    = bus.d_req && !d_ack_q;
    // A real acknowledge beats a coincident timeout; timeout returns zero data.
    assign done      = !bus.m_ack_n || timeout_hit;
    assign rdata_cap = !bus.m_ack_n ? bus.m_rdata : '0;

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        m_req_d   = m_req_q;
        m_write_d = m_write_q;
        m_size_d  = m_size_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (want_d && (!want_i || last_q == SIDE_I)) begin
                    state_d   = GNT_D;
                    m_req_d   = 1'b1;
                    m_write_d = bus.d_write;
                    m_size_d  = bus.d_size;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_write ? bus.d_wdata : '0;
                end else if (want_i) begin
                    state_d   = GNT_I;
                    m_req_d   = 1'b1;
                    m_write_d = 1'b0;
                    m_size_d  = SZ_WORD;
                    m_addr_d  = bus.i_addr;
                    m_wdata_d = '0;
                end
            end

            GNT_I, GNT_D: begin
                if (done) begin
                    state_d   = IDLE;
                    m_req_d   = 1'b0;
                    m_write_d = 1'b0;
                    m_size_d  = SZ_WORD;
                    m_addr_d  = '0;
                    m_wdata_d = '0;
                    err_d     = bus.m_ack_n;
                    if (state_q == GNT_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = rdata_cap;
                        last_d    = SIDE_I;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = rdata_cap;
                        last_d    = SIDE_D;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= SIDE_I;
            m_req_q   <= 1'b0;
            m_write_q <= 1'b0;
            m_size_q  <= SZ_WORD;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            m_req_q   <= m_req_d;
            m_write_q <= m_write_d;
            m_size_q  <= m_size_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
        end
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_write = m_write_q;
    assign bus.m_size  = m_size_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.i_ack   = i_ack_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.err     = err_q;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter and sequencer that shares one external memory bus between the core's instruction-fetch path and its load/store path. It accepts level-held requests from both sides, grants one at a time with round-robin tie-breaking, drives registered bus signals (request, write, size, address, write data), waits for the active-low memory acknowledge, and returns captured read data with a one-cycle ack pulse. It sits between the core and the single-ported memory, replacing the separate instruction and data buses.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, max cycles in a grant state before abort (used only with ARB_TIMEOUT_EN)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  AW  fetch address
- i_rdata  out  DW  fetched instruction, valid while i_ack=1
- i_ack  out  1  one-cycle completion pulse for fetch
- d_req  in  1  load/store request, held until d_ack
- d_write  in  1  1=store, 0=load
- d_size  in  2  00 word, 01 half, 10 byte
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data, valid while d_ack=1
- d_ack  out  1  one-cycle completion pulse for load/store
- m_req  out  1  bus request to memory
- m_write  out  1  bus write enable
- m_size  out  2  bus access size, same encoding as d_size
- m_addr  out  AW  bus address
- m_wdata  out  DW  bus write data
- m_rdata  in  DW  bus read data
- m_ack_n  in  1  memory acknowledge, active-low
- err  out  1  timeout pulse (constant 0 without ARB_TIMEOUT_EN)

## Operation
- States: IDLE, GNT_I, GNT_D.
- IDLE: only i_req -> GNT_I; only d_req -> GNT_D; both -> the side not granted last (last_grant register, reset value I, so the first contention goes to D).
- On entry to GNT_I: m_req=1, m_write=0, m_size=00, m_addr=i_addr, m_wdata=0.
- On entry to GNT_D: m_req=1, m_write=d_write, m_size=d_size, m_addr=d_addr, m_wdata=d_write ? d_wdata : 0.
- Bus outputs are registered and held constant for the whole grant.
- In a grant state, m_ack_n sampled 0 at a rising edge: capture m_rdata into the granted side's rdata, pulse that side's ack for the following cycle, clear all m_* outputs to 0, update last_grant, return to IDLE.
- Ack cycle: the arbiter is in IDLE but ignores the req of the side being acked, giving a one-cycle turnaround for the requester to drop req. The other side may be granted in that cycle.
- i_rdata and d_rdata hold their last captured value between acks.
- m_rdata is captured for stores too, but the requester ignores it.

## Timing
- Reset values: state IDLE, last_grant I, m_req 0, m_write 0, m_size 00, m_addr 0, m_wdata 0, i_ack 0, d_ack 0, i_rdata 0, d_rdata 0, err 0.
- Latency:
  - req high in IDLE at edge n -> m_req=1 from n+1.
  - m_ack_n low at edge k -> x_ack=1 during cycle k+1, m_req=0 from k+1.
  - Minimum transaction: 2 cycles from grant to ack; back-to-back same-side issue every 3 cycles.
- m_ack_n is ignored in IDLE.
- rst asserted mid-grant: abort immediately with no ack pulse and m_req=0 next cycle. The requester must reissue.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A cycle counter (width clog2(TIMEOUT+1)) clears on grant entry and increments each grant cycle.
  - If it reaches TIMEOUT with m_ack_n still 1: return to IDLE, pulse the granted side's ack with rdata=0, pulse err for that same cycle, and release the bus.
  - If ack and timeout coincide on the same edge, the ack wins and err stays 0.
- ARB_TIMEOUT_EN undefined: no counter, a grant waits indefinitely, err tied to 0.

## Structure
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE/GNT_I/GNT_D)
  - the size codes SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10
  - the grant-side encoding
- One sub-module, arb_timeout_ctr (counter plus expiry flag), instantiated only under ARB_TIMEOUT_EN.

## Test plan
- Single fetch: i_req=1, i_addr=0x10000, memory acks after 3 cycles with m_rdata=0x00500093 -> m_req=1 with m_addr=0x10000 and m_size=00; then i_ack one cycle with i_rdata=0x00500093.
- Store: d_req=1, d_write=1, d_size=10, d_addr=0x2004, d_wdata=0xA5 -> m_write=1, m_size=10, m_wdata=0xA5; d_ack one cycle after ack.
- Contention: i_req and d_req both raised from reset, acks immediate -> D granted first, then I; repeated contention alternates D, I, D, I.
- Turnaround: requester keeps i_req high through the i_ack cycle and drops it after -> exactly one fetch, no duplicate grant.
- Reset mid-grant: rst=1 while in GNT_D with m_ack_n=1 -> next cycle m_req=0, d_ack never pulses, all outputs at reset values.
- With ARB_TIMEOUT_EN and TIMEOUT=8: m_ack_n held 1 -> after 8 grant cycles d_ack=1, d_rdata=0, err=1 for one cycle, m_req=0; ack on exactly cycle 8 -> err stays 0.
